// File: rtl/mem_pkg.sv
// Shared types for the SDRAM port arbiter: controller op codes, arbiter
// states, port identifiers and the round-robin pick helper.
package mem_pkg;

    localparam logic [1:0] MC_OP_IDLE  = 2'b00;
    localparam logic [1:0] MC_OP_WRITE = 2'b01;
    localparam logic [1:0] MC_OP_READ  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        REFRESH = 2'd2
    } arb_state_e;

    typedef enum logic {
        PORT_IF = 1'b0,
        PORT_D  = 1'b1
    } port_e;

    // With both ports requesting, the port that did not win last time goes next.
    function automatic port_e rr_pick(input logic if_req, input logic d_req,
                                      input port_e last_grant);
        port_e pick;
        if (if_req && d_req) begin
            pick = (last_grant == PORT_IF) ? PORT_D : PORT_IF;
        end else if (d_req) begin
            pick = PORT_D;
        end else begin
            pick = PORT_IF;
        end
        return pick;
    endfunction

endpackage

// File: rtl/refresh_scheduler.sv
// Auto-refresh interval timer plus saturating count of refreshes still owed
// to the SDRAM; a tick lost at saturation raises a sticky overflow flag.
module refresh_scheduler
    import mem_pkg::*;
#(
    parameter int REF_INTERVAL = 975,
    parameter int REF_PEND_MAX = 8,
    parameter int REF_URGENT   = 4,
    localparam int PW          = $clog2(REF_PEND_MAX + 1)
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ref_done,
    output logic [PW-1:0] ref_pending,
    output logic          ref_urgent,
    output logic          ref_overflow
);

    localparam int            TW           = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(REF_INTERVAL - 1);
    localparam logic [PW-1:0] PEND_MAX     = PW'(REF_PEND_MAX);
    localparam logic [PW-1:0] URGENT_LVL   = PW'(REF_URGENT);

    logic [TW-1:0] timer_q, timer_d;
    logic [PW-1:0] pending_q, pending_d;
    logic          overflow_q, overflow_d;
    logic          tick_s;

    // Interval timer: reload and tick on reaching zero.
    always_comb begin
        tick_s  = 1'b0;
        timer_d = timer_q;
        if (timer_q == TW'(0)) begin
            tick_s  = 1'b1;
            timer_d = TIMER_RELOAD;
        end else begin
            timer_d = timer_q - TW'(1);
        end
    end

    // Pending counter: a tick and a completed refresh in one cycle cancel out.
    always_comb begin
        pending_d  = pending_q;
        overflow_d = overflow_q;
        if (tick_s && !ref_done) begin
            if (pending_q == PEND_MAX) begin
                overflow_d = 1'b1;
            end else begin
                pending_d = pending_q + PW'(1);
            end
        end else if (!tick_s && ref_done) begin
            if (pending_q != PW'(0)) begin
                pending_d = pending_q - PW'(1);
            end else begin
                pending_d = pending_q;
            end
        end else begin
            pending_d = pending_q;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            timer_q    <= TIMER_RELOAD;
            pending_q  <= PW'(0);
            overflow_q <= 1'b0;
        end else begin
            timer_q    <= timer_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

    assign ref_pending  = pending_q;
    assign ref_urgent   = (pending_q >= URGENT_LVL);
    assign ref_overflow = overflow_q;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one SDRAM controller between the fetch and load/store ports, one
// transaction at a time, and slots auto-refresh in between transactions.
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int N            = 64,
    parameter int ADDR_W       = 18,
    parameter int REF_INTERVAL = 975,
    parameter int REF_PEND_MAX = 8,
    parameter int REF_URGENT   = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    output logic [N-1:0]      if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [N-1:0]      d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [N-1:0]      d_rdata,
    output logic [1:0]        mc_op,
    output logic [ADDR_W-1:0] mc_addr,
    output logic [N-1:0]      mc_wdata,
    input  logic [N-1:0]      mc_rdata,
    input  logic              mc_done,
    output logic              mc_ref,
    input  logic              mc_ref_ack,
    output logic              ref_overflow,
    output logic              timeout_err
);

    localparam int            PW        = $clog2(REF_PEND_MAX + 1);
    localparam int            CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    arb_state_e        state_q, state_d;
    port_e             last_grant_q, last_grant_d;
    port_e             owner_q, owner_d;
    port_e             pick_s;
    logic [CW-1:0]     wait_cnt_q, wait_cnt_d;
    logic              if_gnt_q, if_gnt_d, d_gnt_q, d_gnt_d;
    logic              if_valid_q, if_valid_d, d_valid_q, d_valid_d;
    logic [N-1:0]      if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
    logic [1:0]        mc_op_q, mc_op_d;
    logic [ADDR_W-1:0] mc_addr_q, mc_addr_d;
    logic [N-1:0]      mc_wdata_q, mc_wdata_d;
    logic              mc_ref_q, mc_ref_d;
    logic              timeout_err_q, timeout_err_d;
    logic              ref_done_s, ref_urgent_s, ref_overflow_s;
    logic [PW-1:0]     ref_pending_s;

    refresh_scheduler #(
        .REF_INTERVAL (REF_INTERVAL),
        .REF_PEND_MAX (REF_PEND_MAX),
        .REF_URGENT   (REF_URGENT)
    ) u_ref_sched (
        .clk          (clk),
        .reset_n      (reset_n),
        .ref_done     (ref_done_s),
        .ref_pending  (ref_pending_s),
        .ref_urgent   (ref_urgent_s),
        .ref_overflow (ref_overflow_s)
    );

    // Next-state and next-output logic; the controller-facing latch is mc_addr/mc_wdata.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        owner_d       = owner_q;
        wait_cnt_d    = wait_cnt_q;
        if_gnt_d      = 1'b0;
        d_gnt_d       = 1'b0;
        if_valid_d    = 1'b0;
        d_valid_d     = 1'b0;
        if_rdata_d    = if_rdata_q;
        d_rdata_d     = d_rdata_q;
        mc_op_d       = mc_op_q;
        mc_addr_d     = mc_addr_q;
        mc_wdata_d    = mc_wdata_q;
        mc_ref_d      = mc_ref_q;
        timeout_err_d = timeout_err_q;
        ref_done_s    = 1'b0;
        pick_s        = rr_pick(if_req, d_req, last_grant_q);

        case (state_q)
            IDLE: begin
                mc_op_d  = MC_OP_IDLE;
                mc_ref_d = 1'b0;
                if (ref_urgent_s) begin
                    state_d  = REFRESH;
                    mc_ref_d = 1'b1;
                end else if (if_req || d_req) begin
                    state_d      = WAIT;
                    owner_d      = pick_s;
                    last_grant_d = pick_s;
                    wait_cnt_d   = CW'(0);
                    if (pick_s == PORT_D) begin
                        d_gnt_d    = 1'b1;
                        mc_op_d    = d_we ? MC_OP_WRITE : MC_OP_READ;
                        mc_addr_d  = d_addr;
                        mc_wdata_d = d_wdata;
                    end else begin
                        if_gnt_d   = 1'b1;
                        mc_op_d    = MC_OP_READ;
                        mc_addr_d  = if_addr;
                        mc_wdata_d = {N{1'b0}};
                    end
                end else if (ref_pending_s != PW'(0)) begin
                    state_d  = REFRESH;
                    mc_ref_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end

            WAIT: begin
                if (mc_done) begin
                    state_d = IDLE;
                    mc_op_d = MC_OP_IDLE;
                    if (owner_q == PORT_D) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = mc_rdata;
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = mc_rdata;
                    end
                end else if (wait_cnt_q == WAIT_LAST) begin
                    // Abandon the stuck transaction; the owner still gets its valid.
                    state_d       = IDLE;
                    mc_op_d       = MC_OP_IDLE;
                    timeout_err_d = 1'b1;
                    if (owner_q == PORT_D) begin
                        d_valid_d = 1'b1;
                        d_rdata_d = {N{1'b0}};
                    end else begin
                        if_valid_d = 1'b1;
                        if_rdata_d = {N{1'b0}};
                    end
                end else begin
                    wait_cnt_d = wait_cnt_q + CW'(1);
                end
            end

            REFRESH: begin
                mc_op_d = MC_OP_IDLE;
                if (mc_ref_ack) begin
                    state_d    = IDLE;
                    mc_ref_d   = 1'b0;
                    ref_done_s = 1'b1;
                end else begin
                    mc_ref_d = 1'b1;
                end
            end

            default: begin
                state_d  = IDLE;
                mc_op_d  = MC_OP_IDLE;
                mc_ref_d = 1'b0;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            last_grant_q  <= PORT_IF;
            owner_q       <= PORT_IF;
            wait_cnt_q    <= CW'(0);
            if_gnt_q      <= 1'b0;
            d_gnt_q       <= 1'b0;
            if_valid_q    <= 1'b0;
            d_valid_q     <= 1'b0;
            if_rdata_q    <= {N{1'b0}};
            d_rdata_q     <= {N{1'b0}};
            mc_op_q       <= MC_OP_IDLE;
            mc_addr_q     <= {ADDR_W{1'b0}};
            mc_wdata_q    <= {N{1'b0}};
            mc_ref_q      <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            owner_q       <= owner_d;
            wait_cnt_q    <= wait_cnt_d;
            if_gnt_q      <= if_gnt_d;
            d_gnt_q       <= d_gnt_d;
            if_valid_q    <= if_valid_d;
            d_valid_q     <= d_valid_d;
            if_rdata_q    <= if_rdata_d;
            d_rdata_q     <= d_rdata_d;
            mc_op_q       <= mc_op_d;
            mc_addr_q     <= mc_addr_d;
            mc_wdata_q    <= mc_wdata_d;
            mc_ref_q      <= mc_ref_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign if_gnt       = if_gnt_q;
    assign d_gnt        = d_gnt_q;
    assign if_valid     = if_valid_q;
    assign d_valid      = d_valid_q;
    assign if_rdata     = if_rdata_q;
    assign d_rdata      = d_rdata_q;
    assign mc_op        = mc_op_q;
    assign mc_addr      = mc_addr_q;
    assign mc_wdata     = mc_wdata_q;
    assign mc_ref       = mc_ref_q;
    assign timeout_err  = timeout_err_q;
    assign ref_overflow = ref_overflow_s;

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single SDRAM memory controller between the instruction-fetch port and the load/store data port of the core.
- Owns the periodic auto-refresh schedule and forces refresh slots between transactions.
- Sits between the core's memory ports and the controller's op/address/data interface.
- Sequences exactly one outstanding transaction at a time and reports stuck transactions.

Parameters:
N, 64, data width of all data buses
ADDR_W, 18, byte address width
REF_INTERVAL, 975, cycles between refresh ticks (7.8 us at 125 MHz)
REF_PEND_MAX, 8, saturation value of the pending-refresh counter
REF_URGENT, 4, pending count at or above which refresh beats core requests
TIMEOUT, 64, max cycles in WAIT before abort

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
if_req  in  1  fetch read request, level, held until if_gnt
if_addr  in  ADDR_W  fetch address
if_gnt  out  1  one-cycle pulse: fetch request accepted
if_valid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  N  fetch read data
d_req  in  1  data request, level, held until d_gnt
d_we  in  1  1 = write, 0 = read
d_addr  in  ADDR_W  data address
d_wdata  in  N  write data
d_gnt  out  1  one-cycle pulse: data request accepted
d_valid  out  1  one-cycle pulse: read data valid or write acknowledged
d_rdata  out  N  data read result
mc_op  out  2  controller op: 00 idle, 01 write, 10 read
mc_addr  out  ADDR_W  controller address
mc_wdata  out  N  controller write data
mc_rdata  in  N  controller read data, sampled when mc_done = 1
mc_done  in  1  controller pulse: transaction complete
mc_ref  out  1  refresh request, level
mc_ref_ack  in  1  controller pulse: refresh issued
ref_overflow  out  1  sticky: refresh tick lost at saturation
timeout_err  out  1  sticky: transaction aborted by timeout

Behaviour:
- Reset (asynchronous, reset_n = 0):
  - All outputs 0; state IDLE.
  - ref_timer = REF_INTERVAL-1; ref_pending = 0; last_grant = IF.
  - An in-flight transaction is dropped and produces no valid pulse.
- Refresh timer:
  - Decrements every cycle. At 0 it reloads REF_INTERVAL-1 and issues a tick.
  - A tick increments ref_pending, saturating at REF_PEND_MAX.
  - A tick arriving while saturated sets ref_overflow.
  - Tick and acknowledged refresh in the same cycle leave ref_pending unchanged.
- States: IDLE, WAIT, REFRESH. All outputs are registered.
- IDLE decision at each edge, in priority order:
  1. ref_pending >= REF_URGENT -> REFRESH.
  2. Exactly one requester -> grant it.
  3. Both requesters -> grant the one opposite last_grant (round-robin).
  4. No request and ref_pending > 0 -> REFRESH.
  5. Otherwise stay in IDLE.
- Grant at edge k:
  - Latch port, addr, we and wdata into registers.
  - Next cycle: the matching gnt pulses high, and mc_op/mc_addr/mc_wdata are driven from the latch.
  - State -> WAIT; last_grant updated.
  - Requesters must deassert or change req after gnt. req is ignored outside IDLE.
  - IF requests are always reads.
- WAIT:
  - mc_op is held until mc_done.
  - On mc_done at cycle m: the owner's rdata register is loaded from mc_rdata (writes also load it; value unspecified).
  - Owner's valid pulses in cycle m+1; mc_op = 00 in cycle m+1; state -> IDLE.
  - The earliest next grant is visible at m+2.
- Timeout:
  - A WAIT cycle counter reaching TIMEOUT aborts the transaction.
  - mc_op -> 00; owner valid pulses with rdata = 0; timeout_err set.
  - State -> IDLE.
- REFRESH:
  - mc_ref = 1 until mc_ref_ack. On ack, ref_pending decrements.
  - mc_ref drops next cycle; state -> IDLE.
- Ignored inputs:
  - mc_done outside WAIT is ignored.
  - mc_ref_ack outside REFRESH is ignored.
- Invariants:
  - mc_op != 00 and mc_ref = 1 never occur together.
  - At most one gnt and at most one valid per cycle.

Decomposition:
- Package mem_pkg holds:
  - mc_op encodings MC_OP_IDLE/MC_OP_WRITE/MC_OP_READ
  - arbiter state enum (IDLE, WAIT, REFRESH)
  - port-id enum (PORT_IF, PORT_D)
- Sub-module refresh_scheduler:
  - Inputs: clk, reset_n, ref_done.
  - Outputs: ref_pending count, ref_urgent, ref_overflow.
  - Contains the interval timer and the saturating pending counter.

Test Plan:
- Single data read: d_req=1, d_we=0, d_addr=0x00120; mc_done with mc_rdata=0xDEADBEEF_0BADF00D 5 cycles after mc_op=10 -> d_gnt one cycle after request; mc_addr=0x00120; d_valid exactly one cycle after mc_done with d_rdata=0xDEADBEEF_0BADF00D; if_valid stays 0.
- Contention: if_req and d_req held continuously, controller completes each transaction in 3 cycles -> grants alternate D, IF, D, IF; no grant starves; mc_op writes only on D grants with d_we=1.
- Refresh: REF_INTERVAL=20, no requests -> mc_ref rises after each tick; ack after 2 cycles -> ref_pending returns to 0; mc_op stays 00 throughout.
- Urgency: REF_INTERVAL=10, REF_URGENT=2, requests held continuously, controller slow (8 cycles per transaction) -> once ref_pending=2, the next IDLE chooses REFRESH before any grant; ref_overflow is set only after pending reaches 8 and another tick arrives.
- Timeout: data write granted, mc_done never asserted, TIMEOUT=16 -> mc_op returns to 00 after 16 WAIT cycles; d_valid pulses with d_rdata=0; timeout_err=1 and stays set.
- Reset mid-operation: assert reset_n=0 while in WAIT -> all outputs 0 immediately; after release no d_valid appears; a first new request is granted normally.
